// File: rtl/cpu_probe_uart_tx_if.sv
// Probe bus between the CPU datapath and the UART readout block.
// The CPU side drives the trigger and probe nets; the readout side drives the serial pin and status.
interface cpu_probe_uart_tx_if;
    logic        trigger;
    logic [5:0]  uMA;
    logic [7:0]  OPCODE_U0;
    logic [7:0]  cycle;
    logic [7:0]  OPCODE;
    logic [15:0] C;
    logic [10:0] fn;
    logic [15:0] ACC_NUM;
    logic [15:0] ALU_result;
    logic [15:0] ALU_X;
    logic [15:0] buffer_out;
    logic [7:0]  pc;
    logic [7:0]  address_out;
    logic [15:0] memory_data;
    logic [15:0] MR_ACC;
    logic [15:0] MR_NUM;
    logic        tx;
    logic        busy;
    logic        frame_done;

    modport master (
        output trigger, uMA, OPCODE_U0, cycle, OPCODE, C, fn, ACC_NUM, ALU_result,
               ALU_X, buffer_out, pc, address_out, memory_data, MR_ACC, MR_NUM,
        input  tx, busy, frame_done
    );

    modport slave (
        input  trigger, uMA, OPCODE_U0, cycle, OPCODE, C, fn, ACC_NUM, ALU_result,
               ALU_X, buffer_out, pc, address_out, memory_data, MR_ACC, MR_NUM,
        output tx, busy, frame_done
    );
endinterface

// File: rtl/cpu_probe_uart_tx.sv
// Snapshots the CPU probe bus on a trigger and streams it as a 25-byte 8N1 UART frame.
// The header and all probe fields go into one 200-bit register, sent MSB byte first.
module cpu_probe_uart_tx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    cpu_probe_uart_tx_if.slave bus
);
    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [4:0]        LAST_BYTE = 5'd24;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state_reg, state_next;
    logic [BAUD_W-1:0]   baud_reg;
    logic [2:0]          bit_reg;
    logic [4:0]          byte_reg;
    logic                done_reg;
    logic [199:0]        shift_reg;
    logic [199:0]        probe_word;
    logic [7:0]          cur_byte;
    logic                baud_last;
    logic                last_byte;

    assign probe_word = {HEADER, 2'b00, bus.uMA, bus.OPCODE_U0, bus.cycle, bus.OPCODE,
                         bus.C, 5'b00000, bus.fn, bus.ACC_NUM, bus.ALU_result, bus.ALU_X,
                         bus.buffer_out, bus.pc, bus.address_out, bus.memory_data,
                         bus.MR_ACC, bus.MR_NUM};

    assign baud_last = (baud_reg == BAUD_LAST);
    assign last_byte = (byte_reg == LAST_BYTE);
    assign cur_byte  = shift_reg[199:192];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            byte_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == STOP) && baud_last && last_byte;
            if (state_reg == IDLE) begin
                baud_reg <= '0;
                bit_reg  <= '0;
                byte_reg <= '0;
            end else begin
                baud_reg <= baud_last ? '0 : baud_reg + 1'b1;
                if (state_reg == DATA && baud_last)
                    bit_reg <= bit_reg + 3'd1;
                if (state_reg == STOP && baud_last && !last_byte)
                    byte_reg <= byte_reg + 5'd1;
            end
        end
    end

    // Snapshot needs no reset: it is always reloaded before a frame starts.
    always_ff @(posedge clk) begin
        if (state_reg == IDLE && bus.trigger)
            shift_reg <= probe_word;
        else if (state_reg == STOP && baud_last)
            shift_reg <= {shift_reg[191:0], 8'h00};
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (bus.trigger) state_next = START;
            START: if (baud_last) state_next = DATA;
            DATA:  if (baud_last && bit_reg == 3'd7) state_next = STOP;
            STOP:  if (baud_last) state_next = last_byte ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.tx         = 1'b1;
        bus.busy       = (state_reg != IDLE);
        bus.frame_done = done_reg;
        case (state_reg)
            START:   bus.tx = 1'b0;
            DATA:    bus.tx = cur_byte[bit_reg];
            default: bus.tx = 1'b1;
        endcase
    end
endmodule
